coef_run_expander: RTL and testbench

- Sits directly downstream of the VLI decoder in the JPEG entropy-decode path.
- Consumes one decoded symbol per handshake: run, size, signed value, DC/AC tag and component ID.
- Expands run-lengths, ZRL and EOB into a dense stream of 64 coefficients per block, in zigzag index order.
- Applies per-component DC prediction and feeds the dequantiser/de-zigzag stage one coefficient per cycle.

---
 rtl/coef_run_expander.sv | 260 ++++++++++++++++++++++++++
 tb/tb_coef_run_expander.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_run_expander.sv
// Expands decoded JPEG run/size/value symbols into 64 zigzag-ordered coefficients per block.
// Optional JPEG_DC_PRED_EN adds per-component DC predictors; without it DC is emitted as the raw difference.
module coef_run_expander #(
  parameter int COEF_W   = 16,
  parameter int NUM_COMP = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_dc,
  input  logic [1:0]        in_comp,
  input  logic [3:0]        in_run,
  input  logic [3:0]        in_size,
  input  logic [11:0]       in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic [1:0]        out_comp,
  output logic              err
);

  // state   | meaning
  // WAIT_DC | idle between blocks, expecting a DC symbol
  // WAIT_AC | inside a block, expecting an AC symbol
  // ZEROS   | emitting the remaining zeros of a run
  // VALUE   | emitting the pending nonzero AC value
  // FILL    | emitting zeros after EOB up to index 63
  typedef enum logic [2:0] {
    S_WAIT_DC, S_WAIT_AC, S_ZEROS, S_VALUE, S_FILL
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        k_q, k_d;
  logic [3:0]        zeros_q, zeros_d;
  logic              pend_q, pend_d;
  logic [11:0]       pval_q, pval_d;
  logic [1:0]        comp_q, comp_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [COEF_W-1:0] out_coef_q, out_coef_d;
  logic [5:0]        out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic [1:0]        out_comp_q, out_comp_d;

  logic              free, accept, do_dc, emit, dc_bad;
  logic [COEF_W-1:0] emit_coef, dc_coef;
  logic [3:0]        rem_z;
  logic              rem_p, rem_fill;

  function automatic logic [COEF_W-1:0] sext(input logic [11:0] v);
    return {{(COEF_W-12){v[11]}}, v};
  endfunction

`ifdef JPEG_DC_PRED_EN
  logic [COEF_W-1:0] pred_q [NUM_COMP];
  logic [COEF_W-1:0] pred_d [NUM_COMP];
  logic [COEF_W-1:0] pred_sel;
`endif

  assign free      = !out_valid_q || out_ready;
  assign in_ready  = ((state_q == S_WAIT_DC) || (state_q == S_WAIT_AC)) && free;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign out_comp  = out_comp_q;
  assign err       = err_q;

  // Out-of-range components fall back to predictor 0.
  always_comb begin
    dc_bad = int'(in_comp) >= NUM_COMP;
`ifdef JPEG_DC_PRED_EN
    pred_sel = pred_q[0];
    for (int c = 0; c < NUM_COMP; c++) begin
      if (!dc_bad && in_comp == 2'(c)) pred_sel = pred_q[c];
    end
    dc_coef = pred_sel + sext(in_value);
`else
    dc_coef = sext(in_value);
`endif
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    zeros_d     = zeros_q;
    pend_d      = pend_q;
    pval_d      = pval_q;
    comp_d      = comp_q;
    err_d       = err_q;
    out_valid_d = out_valid_q && !out_ready;
    out_coef_d  = out_coef_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_comp_d  = out_comp_q;
`ifdef JPEG_DC_PRED_EN
    pred_d      = pred_q;
`endif
    do_dc       = 1'b0;
    emit        = 1'b0;
    emit_coef   = '0;
    rem_z       = '0;
    rem_p       = 1'b0;
    rem_fill    = 1'b0;

    case (state_q)
      S_WAIT_DC: begin
        if (accept) begin
          if (in_is_dc) do_dc = 1'b1;
          else          err_d = 1'b1;
        end
      end
      S_WAIT_AC: begin
        if (accept) begin
          if (in_is_dc) begin
            err_d = 1'b1;
            do_dc = 1'b1;
          end else begin
            // The first coefficient of every symbol goes out on acceptance.
            emit = 1'b1;
            if (in_size == 4'd0) begin
              if (in_run == 4'd15) begin
                rem_z = 4'd15;
              end else begin
                rem_fill = 1'b1;
                if (in_run != 4'd0) err_d = 1'b1;
              end
            end else if (in_run == 4'd0) begin
              emit_coef = sext(in_value);
            end else begin
              rem_z  = in_run - 4'd1;
              rem_p  = 1'b1;
              pval_d = in_value;
            end
          end
        end
      end
      S_ZEROS: begin
        if (free) begin
          emit  = 1'b1;
          rem_z = zeros_q - 4'd1;
          rem_p = pend_q;
        end
      end
      S_VALUE: begin
        if (free) begin
          emit      = 1'b1;
          emit_coef = sext(pval_q);
        end
      end
      S_FILL: begin
        if (free) begin
          emit     = 1'b1;
          rem_fill = 1'b1;
        end
      end
      default: state_d = S_WAIT_DC;
    endcase

    if (do_dc) begin
      if (dc_bad) err_d = 1'b1;
`ifdef JPEG_DC_PRED_EN
      for (int c = 0; c < NUM_COMP; c++) begin
        if ((dc_bad && c == 0) || (!dc_bad && in_comp == 2'(c))) pred_d[c] = dc_coef;
      end
`endif
      out_valid_d = 1'b1;
      out_coef_d  = dc_coef;
      out_index_d = 6'd0;
      out_last_d  = 1'b0;
      out_comp_d  = in_comp;
      comp_d      = in_comp;
      k_d         = 6'd1;
      zeros_d     = '0;
      pend_d      = 1'b0;
      state_d     = S_WAIT_AC;
    end else if (emit) begin
      out_valid_d = 1'b1;
      out_coef_d  = emit_coef;
      out_index_d = k_q;
      out_last_d  = (k_q == 6'd63);
      out_comp_d  = comp_q;
      if (k_q == 6'd63) begin
        // Anything still owed past index 63 is a run overflow.
        if (rem_z != 4'd0 || rem_p) err_d = 1'b1;
        k_d     = 6'd0;
        zeros_d = '0;
        pend_d  = 1'b0;
        state_d = S_WAIT_DC;
      end else begin
        k_d     = k_q + 6'd1;
        zeros_d = rem_z;
        pend_d  = rem_p;
        if (rem_z != 4'd0) state_d = S_ZEROS;
        else if (rem_p)    state_d = S_VALUE;
        else if (rem_fill) state_d = S_FILL;
        else               state_d = S_WAIT_AC;
      end
    end

    if (restart) begin
      state_d     = S_WAIT_DC;
      k_d         = 6'd0;
      zeros_d     = '0;
      pend_d      = 1'b0;
      err_d       = 1'b0;
      out_valid_d = out_valid_q && !out_ready;
      out_coef_d  = out_coef_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      out_comp_d  = out_comp_q;
      comp_d      = comp_q;
`ifdef JPEG_DC_PRED_EN
      for (int c = 0; c < NUM_COMP; c++) pred_d[c] = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_WAIT_DC;
      k_q         <= '0;
      zeros_q     <= '0;
      pend_q      <= 1'b0;
      pval_q      <= '0;
      comp_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_comp_q  <= '0;
`ifdef JPEG_DC_PRED_EN
      for (int c = 0; c < NUM_COMP; c++) pred_q[c] <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      zeros_q     <= zeros_d;
      pend_q      <= pend_d;
      pval_q      <= pval_d;
      comp_q      <= comp_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_comp_q  <= out_comp_d;
`ifdef JPEG_DC_PRED_EN
      pred_q      <= pred_d;
`endif
    end
  end

endmodule

// File: tb/tb_coef_run_expander.sv
// Directed bench for coef_run_expander: block-level reference model plus literal spot values.
// Follows JPEG_DC_PRED_EN to pick predictor or raw-difference DC expectations.
module tb_coef_run_expander;
  localparam int COEF_W = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              restart = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_is_dc = 1'b0;
  logic [1:0]        in_comp = '0;
  logic [3:0]        in_run = '0;
  logic [3:0]        in_size = '0;
  logic [11:0]       in_value = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [COEF_W-1:0] out_coef;
  logic [5:0]        out_index;
  logic              out_last;
  logic [1:0]        out_comp;
  logic              err;

  coef_run_expander #(.COEF_W(COEF_W), .NUM_COMP(3)) dut (
    .clock(clock), .reset_n(reset_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_dc(in_is_dc),
    .in_comp(in_comp), .in_run(in_run), .in_size(in_size), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_coef(out_coef),
    .out_index(out_index), .out_last(out_last), .out_comp(out_comp), .err(err)
  );

  always #5 clock = ~clock;

`ifdef JPEG_DC_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  typedef struct {
    logic [15:0] coef;
    int          idx;
    logic [1:0]  comp;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  int          obs[64];
  int          last_cnt = 0;

  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [1:0]  m_comp = '0;
  logic [15:0] m_pred[3];
  bit          m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_pred[i] = '0;
    m_err    = 1'b0;
    m_active = 1'b0;
    m_pos    = 0;
  endtask

  task automatic push(input int idx, input logic [15:0] v);
    exp_t e;
    e.coef = v;
    e.idx  = idx;
    e.comp = m_comp;
    q.push_back(e);
  endtask

  // Block model: positions advance by run length; anything past 63 is dropped and flagged.
  task automatic model_sym(input bit dc, input int comp, input int run, input int size, input int value);
    logic [11:0] v12;
    int          sv, z, idx;
    bit          hasv;
    v12 = 12'(value);
    sv  = int'($signed(v12));
    if (dc) begin
      if (m_active) m_err = 1'b1;
      idx = comp;
      if (comp >= 3) begin
        m_err = 1'b1;
        idx = 0;
      end
      m_comp = 2'(comp);
      if (PRED) begin
        m_pred[idx] = m_pred[idx] + 16'(sv);
        push(0, m_pred[idx]);
      end else begin
        push(0, 16'(sv));
      end
      m_pos    = 1;
      m_active = 1'b1;
    end else if (!m_active) begin
      m_err = 1'b1;
    end else begin
      hasv = 1'b0;
      if (size == 0) begin
        if (run == 15) begin
          z = 16;
        end else begin
          if (run != 0) m_err = 1'b1;
          z = 64 - m_pos;
        end
      end else begin
        z    = run;
        hasv = 1'b1;
      end
      for (int i = 0; i < z; i++) begin
        if (m_pos < 64) begin
          push(m_pos, 16'd0);
          m_pos++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (hasv) begin
        if (m_pos < 64) begin
          push(m_pos, 16'(sv));
          m_pos++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_pos >= 64) m_active = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every handshake against the model queue, plus hold-while-stalled.
  initial begin
    exp_t        e;
    logic [15:0] pc;
    int          pi;
    bit          ps;
    ps = 1'b0;
    pc = '0;
    pi = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          checks++;
          if (!out_valid || out_coef !== pc || int'(out_index) != pi) begin
            errors++;
            $display("FAIL stall_hold actual=%0b/%0h/%0d required=1/%0h/%0d",
                     out_valid, out_coef, out_index, pc, pi);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_coef actual=idx%0d/%0h required=none", out_index, out_coef);
          end else begin
            e = q.pop_front();
            if (out_coef !== e.coef || int'(out_index) != e.idx ||
                out_last !== (e.idx == 63) || out_comp !== e.comp) begin
              errors++;
              $display("FAIL coef actual=idx%0d/%0h/last%0b/c%0d required=idx%0d/%0h/last%0b/c%0d",
                       out_index, out_coef, out_last, out_comp, e.idx, e.coef, (e.idx == 63), e.comp);
            end
          end
          obs[out_index] = int'($signed(out_coef));
          if (out_last) last_cnt++;
        end
        ps = out_valid && !out_ready;
        pc = out_coef;
        pi = int'(out_index);
      end
    end
  end

  task automatic send(input bit dc, input int comp, input int run, input int size, input int value);
    int cnt;
    bit ok;
    in_is_dc = dc;
    in_comp  = 2'(comp);
    in_run   = 4'(run);
    in_size  = 4'(size);
    in_value = 12'(value);
    in_valid = 1'b1;
    cnt = 0;
    ok  = 1'b0;
    while (!ok && cnt < 500) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        ok = 1'b1;
      end else begin
        cnt++;
      end
    end
    in_valid = 1'b0;
    if (ok) model_sym(dc, comp, run, size, value);
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (q.size() != 0 && cnt < 3000) begin
      @(negedge clock);
      cnt++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) obs[i] = 12345;
    last_cnt = 0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clock);
    #1;
    restart = 1'b0;
    model_clear();
  endtask

  task automatic check_err();
    chk("err_model", int'(err), int'(m_err));
  endtask

  int r1[3];
  int r2[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    r1 = '{10, 20, 30};
    if (PRED) r2 = '{20, 40, 60};
    else      r2 = '{10, 20, 30};
    model_clear();
    clear_obs();

    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_coef", int'(out_coef), 0);
    chk("rst_index", int'(out_index), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_comp", int'(out_comp), 0);
    chk("rst_err", int'(err), 0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // DC then EOB, twice on comp 0
    send(1, 0, 0, 3, 5);
    send(0, 0, 0, 0, 0);
    wait_drain();
    chk("blk1_dc", obs[0], 5);
    chk("blk1_k1", obs[1], 0);
    chk("blk1_k63", obs[63], 0);
    chk("blk1_last", last_cnt, 1);
    clear_obs();
    send(1, 0, 0, 2, -3);
    send(0, 0, 0, 0, 0);
    wait_drain();
    chk("blk2_dc", obs[0], PRED ? 2 : -3);
    check_err();

    // run of 2 then value -7
    clear_obs();
    send(1, 0, 0, 0, 0);
    send(0, 0, 2, 3, -7);
    send(0, 0, 0, 0, 0);
    wait_drain();
    chk("run2_k2", obs[2], 0);
    chk("run2_k3", obs[3], -7);
    chk("run2_k4", obs[4], 0);
    chk("run2_last", last_cnt, 1);
    check_err();

    // size 0 with run 3 behaves as EOB and flags err
    clear_obs();
    send(1, 1, 0, 1, 1);
    send(0, 1, 3, 0, 0);
    wait_drain();
    chk("badeob_err", int'(err), 1);
    chk("badeob_k1", obs[1], 0);
    chk("badeob_last", last_cnt, 1);
    check_err();
    do_restart();
    chk("restart_err", int'(err), 0);

    // 3 ZRL then 15/3 overflows: value dropped at block end
    clear_obs();
    send(1, 0, 0, 0, 0);
    send(0, 0, 15, 0, 0);
    send(0, 0, 15, 0, 0);
    send(0, 0, 15, 0, 0);
    send(0, 0, 15, 3, 4);
    wait_drain();
    chk("ovf_err", int'(err), 1);
    chk("ovf_k48", obs[48], 0);
    chk("ovf_k63", obs[63], 0);
    chk("ovf_last", last_cnt, 1);
    clear_obs();
    send(0, 0, 0, 1, 1);
    send(1, 1, 0, 3, 5);
    send(0, 1, 0, 0, 0);
    wait_drain();
    chk("newblk_dc", obs[0], 5);
    chk("newblk_last", last_cnt, 1);
    check_err();
    do_restart();

    // 62 unit AC values then EOB, with random backpressure
    clear_obs();
    rand_ready = 1'b1;
    send(1, 2, 0, 0, 0);
    for (int i = 0; i < 62; i++) send(0, 2, 0, 1, 1);
    send(0, 2, 0, 0, 0);
    wait_drain();
    rand_ready = 1'b0;
    chk("full_k1", obs[1], 1);
    chk("full_k62", obs[62], 1);
    chk("full_k63", obs[63], 0);
    chk("full_last", last_cnt, 1);
    check_err();

    // interleaved components, two rounds, then again after restart
    do_restart();
    for (int pass = 0; pass < 2; pass++) begin
      for (int rnd = 0; rnd < 2; rnd++) begin
        for (int c = 0; c < 3; c++) begin
          clear_obs();
          send(1, c, 0, 5, (c + 1) * 10);
          send(0, c, 0, 0, 0);
          wait_drain();
          chk($sformatf("dc_p%0d_r%0d_c%0d", pass, rnd, c), obs[0], (rnd == 0) ? r1[c] : r2[c]);
        end
      end
      if (pass == 0) do_restart();
    end
    check_err();

    // reset in the middle of a block
    send(1, 1, 0, 4, 9);
    send(0, 1, 0, 0, 0);
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_coef", int'(out_coef), 0);
    chk("midrst_index", int'(out_index), 0);
    chk("midrst_comp", int'(out_comp), 0);
    q.delete();
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    clear_obs();
    send(1, 0, 0, 4, 10);
    send(0, 0, 0, 0, 0);
    wait_drain();
    chk("postrst_dc", obs[0], 10);

    // out-of-range component uses predictor 0 and flags err
    clear_obs();
    send(1, 3, 0, 3, 4);
    send(0, 3, 0, 0, 0);
    wait_drain();
    chk("badcomp_dc", obs[0], PRED ? 14 : 4);
    chk("badcomp_err", int'(err), 1);
    check_err();

    repeat (4) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
